fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised successor to the single-cycle forwarding unit.
- Keeps its own shift-register scoreboard of in-flight writers across NUM_STG post-ID stages. Stage 1 = EX, 2 = MEM, 3 = WB by default.
- Per source operand, it picks the youngest matching producer, or the register file.
- Raises a load-use / no-forwarding stall, inserts bubbles, honours freeze and flush, and keeps saturating stall and forward counters for perf monitoring.

Parameters:
- REG_W, 4: register address width.
- NUM_STG, 3: number of tracked stages after ID (>=2).
- LOAD_FWD_STG, 2: first stage from which a load result may be forwarded (1..NUM_STG).
- SEL_W, 2: select width; must satisfy 2^SEL_W > NUM_STG.
- CNT_W, 16: perf counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en_forwarding  in  1  1 = forwarding allowed; 0 = stall on every dependency.
- freeze  in  1  global pipeline hold (e.g. memory wait); scoreboard and counters hold.
- flush  in  1  kill the instruction in ID (branch taken).
- id_valid  in  1  ID holds a real instruction.
- id_src1, id_src2  in  REG_W  source register numbers.
- id_src1_used, id_src2_used  in  1  operand actually read.
- id_wb_en  in  1  ID instruction writes a register.
- id_dst  in  REG_W  destination register.
- id_is_load  in  1  ID instruction is a memory load.
- clr_cnt  in  1  synchronous clear of both counters.
- sel_src1, sel_src2  out  SEL_W  0 = register file, k = forward from stage k.
- stall  out  1  hold IF/ID; bubble into EX.
- stall_cnt  out  CNT_W  cycles with stall=1 (saturating).
- fwd_cnt  out  CNT_W  cycles with any sel != 0 (saturating).

Behaviour:
- Scoreboard entry per stage k = 1..NUM_STG: {v, wb_en, dst, ld}. On reset, all v = 0 and counters = 0. Outputs are therefore sel = 0, stall = 0, counts = 0.
- Match for src s at stage k: v[k] & wb_en[k] & dst[k] == s & src_used & id_valid. The lowest k (youngest) wins; older matches are ignored.
- Combinational decision per operand, from the winning k:
  - en_forwarding = 0: stall = 1, sel = 0.
  - ld[k] = 1 and k < LOAD_FWD_STG: stall = 1, sel = 0.
  - Otherwise: sel = k.
  - No match: sel = 0.
- stall = OR over both operands, gated by !flush. When stall = 1, both sel outputs are forced to 0.
- Update on rising clk, when freeze = 0:
  - Stages k >= 2 take entry k-1; stage NUM_STG's old entry is dropped.
  - Stage 1 takes the ID fields with v = id_valid & !stall & !flush. Otherwise stage 1 gets a bubble (v = 0).
- When freeze = 1, every entry holds and the counters hold. The combinational outputs still track the current inputs.
- flush and stall together: flush wins, so stage 1 gets a bubble and stall = 0.
- Self-dependency (src == dst of the same ID instruction) is not a hazard.
- Counters:
  - Each increments by 1 per non-frozen cycle in which its condition holds, and saturates at all-ones.
  - clr_cnt has priority over increment and also acts during freeze.
- Asynchronous reset mid-operation immediately clears all entries and counters, and outputs drop to 0 in the same cycle.
- Latency: a producer issued in cycle t is visible as stage 1 in cycle t+1 and as stage k in cycle t+k. It leaves after cycle t+NUM_STG.

Test Plan:
- ALU back-to-back, defaults: cycle 0 ID issues r3 <- ..., cycle 1 ID reads src1 = r3 -> sel_src1 = 1, stall = 0, fwd_cnt = 1.
- Load-use: cycle 0 issues a load to r5, cycle 1 reads r5 -> stall = 1, stage 1 bubble. Cycle 2 -> sel = 2, stall = 0. stall_cnt = 1.
- Youngest wins: r2 written at stage 3 and at stage 1, both srcs = r2 -> sel_src1 = sel_src2 = 1. With en_forwarding = 0 -> stall = 1 for 3 cycles until r2 leaves stage 3; stall_cnt = 3.
- Freeze: dependency pending at stage 1, freeze high 4 cycles -> sel stays 1, entries hold, counters unchanged. After release, the entry advances to stage 2.
- Flush plus stall: load-use condition with flush = 1 -> stall = 0, stage 1 v = 0, stall_cnt unchanged.
- Reset and saturation: preload stall_cnt to all-ones -> it stays all-ones. Assert rst low mid-stream -> all outputs 0 immediately. clr_cnt -> counters 0 next edge.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writers across NUM_STG
// post-ID stages, selects the youngest matching producer per source operand,
// raises a stall when a result cannot be forwarded yet, and keeps saturating
// stall/forward counters for performance monitoring.
module fwd_scoreboard #(
   parameter int REG_W        = 4,
   parameter int NUM_STG      = 3,
   parameter int LOAD_FWD_STG = 2,
   parameter int SEL_W        = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_forwarding,
   input  logic             freeze,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_src1_used,
   input  logic             id_src2_used,
   input  logic             id_wb_en,
   input  logic [REG_W-1:0] id_dst,
   input  logic             id_is_load,
   input  logic             clr_cnt,
   output logic [SEL_W-1:0] sel_src1,
   output logic [SEL_W-1:0] sel_src2,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] fwd_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Winning producer for one operand: hit flag, its stage number, load flag.
   typedef struct packed {
      logic             hit;
      logic [SEL_W-1:0] stg;
      logic             ld;
   } pick_t;

   // Scoreboard entries, index k = stage k (1 = EX).
   logic [NUM_STG:1] v_r;
   logic [NUM_STG:1] wb_r;
   logic [NUM_STG:1] ld_r;
   logic [REG_W-1:0] dst_r [1:NUM_STG];

   pick_t m1_s;
   pick_t m2_s;
   logic  need1_s;
   logic  need2_s;
   logic  stall_s;

   // Youngest-match search: scan oldest to youngest so the lowest stage wins.
   always_comb begin
      m1_s = '0;
      m2_s = '0;
      for (int k = NUM_STG; k >= 1; k--) begin
         if (v_r[k] && wb_r[k] && (dst_r[k] == id_src1) && id_src1_used && id_valid) begin
            m1_s.hit = 1'b1;
            m1_s.stg = SEL_W'(k);
            m1_s.ld  = ld_r[k];
         end else begin
            m1_s = m1_s;
         end
         if (v_r[k] && wb_r[k] && (dst_r[k] == id_src2) && id_src2_used && id_valid) begin
            m2_s.hit = 1'b1;
            m2_s.stg = SEL_W'(k);
            m2_s.ld  = ld_r[k];
         end else begin
            m2_s = m2_s;
         end
      end
   end

   // Hazard decision: a match must stall when forwarding is off or a load
   // result is not available yet; a stall kills both selects, flush kills stall.
   always_comb begin
      need1_s  = m1_s.hit && (!en_forwarding || (m1_s.ld && (int'(m1_s.stg) < LOAD_FWD_STG)));
      need2_s  = m2_s.hit && (!en_forwarding || (m2_s.ld && (int'(m2_s.stg) < LOAD_FWD_STG)));
      stall_s  = (need1_s || need2_s) && !flush;
      stall    = stall_s;
      sel_src1 = '0;
      sel_src2 = '0;
      if (!stall_s && m1_s.hit && !need1_s) begin
         sel_src1 = m1_s.stg;
      end else begin
         sel_src1 = '0;
      end
      if (!stall_s && m2_s.hit && !need2_s) begin
         sel_src2 = m2_s.stg;
      end else begin
         sel_src2 = '0;
      end
   end

   // Scoreboard shift: entries age one stage per non-frozen cycle; stage 1
   // receives the ID instruction or a bubble when stalled or flushed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_r  <= '0;
         wb_r <= '0;
         ld_r <= '0;
         for (int k = 1; k <= NUM_STG; k++) begin
            dst_r[k] <= '0;
         end
      end else if (!freeze) begin
         for (int k = NUM_STG; k >= 2; k--) begin
            v_r[k]   <= v_r[k-1];
            wb_r[k]  <= wb_r[k-1];
            ld_r[k]  <= ld_r[k-1];
            dst_r[k] <= dst_r[k-1];
         end
         v_r[1]   <= id_valid && !stall_s && !flush;
         wb_r[1]  <= id_wb_en;
         ld_r[1]  <= id_is_load;
         dst_r[1] <= id_dst;
      end else begin
         v_r  <= v_r;
         wb_r <= wb_r;
         ld_r <= ld_r;
      end
   end

   // Saturating perf counters; clear beats increment and works even when frozen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else if (clr_cnt) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else if (!freeze) begin
         if (stall_s && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end else begin
            stall_cnt <= stall_cnt;
         end
         if (((sel_src1 != '0) || (sel_src2 != '0)) && (fwd_cnt != CNT_MAX)) begin
            fwd_cnt <= fwd_cnt + CNT_ONE;
         end else begin
            fwd_cnt <= fwd_cnt;
         end
      end else begin
         stall_cnt <= stall_cnt;
         fwd_cnt   <= fwd_cnt;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed cycle table, hand-written
// freeze/flush/saturation/reset sequences and randomized traffic against a
// queue-based model of in-flight producers. A second instance with 4-bit
// counters exercises saturation in a short run.
module tb_fwd_scoreboard;
   localparam int REG_W = 4, NUM_STG = 3, LOAD_FWD_STG = 2, SEL_W = 2;
   localparam int CNT_W = 16, CNT_W_S = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en_forwarding, freeze, flush, id_valid, id_src1_used, id_src2_used;
   logic id_wb_en, id_is_load, clr_cnt;
   logic [REG_W-1:0] id_src1, id_src2, id_dst;
   logic [SEL_W-1:0] sel_src1, sel_src2, s_sel_src1, s_sel_src2;
   logic stall, s_stall;
   logic [CNT_W-1:0] stall_cnt, fwd_cnt;
   logic [CNT_W_S-1:0] s_stall_cnt, s_fwd_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fwd_scoreboard dut (
      .clk(clk), .rst(rst), .en_forwarding(en_forwarding), .freeze(freeze), .flush(flush),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_wb_en(id_wb_en),
      .id_dst(id_dst), .id_is_load(id_is_load), .clr_cnt(clr_cnt),
      .sel_src1(sel_src1), .sel_src2(sel_src2), .stall(stall),
      .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt));

   fwd_scoreboard #(.CNT_W(CNT_W_S)) dut_s (
      .clk(clk), .rst(rst), .en_forwarding(en_forwarding), .freeze(freeze), .flush(flush),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_wb_en(id_wb_en),
      .id_dst(id_dst), .id_is_load(id_is_load), .clr_cnt(clr_cnt),
      .sel_src1(s_sel_src1), .sel_src2(s_sel_src2), .stall(s_stall),
      .stall_cnt(s_stall_cnt), .fwd_cnt(s_fwd_cnt));

   // ---------------- reference model ----------------
   typedef struct { logic v; logic wb; logic [REG_W-1:0] dst; logic ld; } slot_t;
   slot_t inflight[$];     // element 0 = issued one cycle ago (stage 1)
   int stall_n;
   int fwd_n;

   function automatic logic [31:0] sat(int n, int w);
      int mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   function automatic void operand(input logic [REG_W-1:0] src, input logic used,
                                   output int sel, output bit haz);
      sel = 0;
      haz = 1'b0;
      if (!(id_valid && used)) return;
      for (int i = 0; i < inflight.size(); i++) begin
         if (inflight[i].v && inflight[i].wb && inflight[i].dst == src) begin
            if (!en_forwarding || (inflight[i].ld && (i + 1) < LOAD_FWD_STG)) haz = 1'b1;
            else sel = i + 1;
            return;
         end
      end
   endfunction

   function automatic void model_eval(output int e1, output int e2, output bit est);
      bit h1, h2;
      operand(id_src1, id_src1_used, e1, h1);
      operand(id_src2, id_src2_used, e2, h2);
      est = (h1 || h2) && !flush;
      if (est) begin
         e1 = 0;
         e2 = 0;
      end
   endfunction

   function automatic void model_clock(input int e1, input int e2, input bit est);
      slot_t s;
      if (clr_cnt) begin
         stall_n = 0;
         fwd_n = 0;
      end else if (!freeze) begin
         if (est) stall_n++;
         if (e1 != 0 || e2 != 0) fwd_n++;
      end
      if (!freeze) begin
         s.v = id_valid && !est && !flush;
         s.wb = id_wb_en;
         s.dst = id_dst;
         s.ld = id_is_load;
         inflight.push_front(s);
         while (inflight.size() > NUM_STG) void'(inflight.pop_back());
      end
   endfunction

   function automatic void model_reset();
      slot_t b;
      b.v = 1'b0; b.wb = 1'b0; b.dst = '0; b.ld = 1'b0;
      inflight.delete();
      for (int i = 0; i < NUM_STG; i++) inflight.push_back(b);
      stall_n = 0;
      fwd_n = 0;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [REG_W-1:0] s1, input logic u1,
                        input logic [REG_W-1:0] s2, input logic u2, input logic wb,
                        input logic [REG_W-1:0] dst, input logic ld);
      id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
      id_wb_en = wb; id_dst = dst; id_is_load = ld;
   endtask

   // Called just after a rising edge: checks combinational outputs mid-cycle
   // (against table values when use_tab, else the model), then counters after the edge.
   task automatic cycle(input string tag, input bit use_tab, input int t1, input int t2, input bit tst);
      int e1, e2;
      bit est;
      #3;
      model_eval(e1, e2, est);
      if (use_tab) begin
         e1 = t1; e2 = t2; est = tst;
      end
      chk({tag, "_sel1"}, 32'(sel_src1), 32'(e1));
      chk({tag, "_sel2"}, 32'(sel_src2), 32'(e2));
      chk({tag, "_stall"}, 32'(stall), 32'(est));
      @(posedge clk);
      model_clock(e1, e2, est);
      #1;
      chk({tag, "_stall_cnt"}, 32'(stall_cnt), sat(stall_n, CNT_W));
      chk({tag, "_fwd_cnt"}, 32'(fwd_cnt), sat(fwd_n, CNT_W));
      chk({tag, "_s_stall_cnt"}, 32'(s_stall_cnt), sat(stall_n, CNT_W_S));
      chk({tag, "_s_fwd_cnt"}, 32'(s_fwd_cnt), sat(fwd_n, CNT_W_S));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      en_forwarding = 1'b1; freeze = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      chk("reset_sel1", 32'(sel_src1), 32'd0);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("reset_fwd_cnt", 32'(fwd_cnt), 32'd0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic v; logic [REG_W-1:0] s1; logic u1; logic [REG_W-1:0] s2; logic u2;
      logic wb; logic [REG_W-1:0] dst; logic ld; logic en;
      int e1; int e2; bit est;
   } vec_t;
   vec_t tab[22];

   initial begin
      // v  s1    u1    s2    u2    wb    dst   ld    en    sel1 sel2 stall
      tab[0]  = '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 0, 0, 1'b0};
      tab[1]  = '{1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1, 0, 1'b0};
      tab[2]  = '{1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 2, 0, 1'b0};
      tab[3]  = '{1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 0, 0, 1'b1};
      tab[4]  = '{1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 0, 2, 1'b0};
      tab[5]  = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 0, 0, 1'b0};
      tab[6]  = '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 0, 0, 1'b0};
      tab[7]  = '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 0, 0, 1'b0};
      tab[8]  = '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 0, 0, 1'b0};
      tab[9]  = '{1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1, 1, 1'b0};
      tab[10] = '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 0, 0, 1'b0};
      tab[11] = '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 0, 0, 1'b0};
      tab[12] = '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 0, 0, 1'b0};
      tab[13] = '{1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 0, 0, 1'b1};
      tab[14] = '{1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 0, 0, 1'b1};
      tab[15] = '{1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 0, 0, 1'b1};
      tab[16] = '{1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0};
      tab[17] = '{1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 0, 0, 1'b0};
      tab[18] = '{1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1, 0, 1'b0};
      tab[19] = '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 0, 0, 1'b0};
      tab[20] = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 0, 0, 1'b0};
      tab[21] = '{1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 0, 2, 1'b0};

      do_reset();
      for (int i = 0; i < 22; i++) begin
         drive(tab[i].v, tab[i].s1, tab[i].u1, tab[i].s2, tab[i].u2, tab[i].wb, tab[i].dst, tab[i].ld);
         en_forwarding = tab[i].en;
         cycle($sformatf("tab%0d", i), 1'b1, tab[i].e1, tab[i].e2, tab[i].est);
         if (i == 1) chk("alu_b2b_fwd_cnt", 32'(fwd_cnt), 32'd1);
         if (i == 4) chk("load_use_stall_cnt", 32'(stall_cnt), 32'd1);
         if (i == 16) chk("youngest_stall_cnt", 32'(stall_cnt), 32'd4);
      end

      // Freeze: pending dependency at stage 1 holds for 4 frozen cycles.
      do_reset();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0);
      cycle("frz_issue", 1'b0, 0, 0, 1'b0);
      drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      freeze = 1'b1;
      for (int i = 0; i < 4; i++) cycle("frz_hold", 1'b1, 1, 0, 1'b0);
      chk("frz_fwd_cnt_held", 32'(fwd_cnt), 32'd0);
      freeze = 1'b0;
      cycle("frz_release", 1'b1, 1, 0, 1'b0);
      chk("frz_fwd_cnt_after", 32'(fwd_cnt), 32'd1);
      cycle("frz_advanced", 1'b1, 2, 0, 1'b0);

      // Flush together with a load-use hazard: no stall, stage 1 gets a bubble.
      do_reset();
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1);
      cycle("fl_load", 1'b0, 0, 0, 1'b0);
      drive(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0);
      flush = 1'b1;
      cycle("fl_flush", 1'b1, 0, 0, 1'b0);
      flush = 1'b0;
      drive(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      cycle("fl_after", 1'b1, 2, 0, 1'b0);
      chk("fl_stall_cnt", 32'(stall_cnt), 32'd0);

      // Saturation on the 4-bit instance, then clear during freeze.
      do_reset();
      en_forwarding = 1'b0;
      drive(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
      for (int i = 0; i < 30; i++) cycle("sat_stall", 1'b0, 0, 0, 1'b0);
      chk("sat_s_stall_cnt", 32'(s_stall_cnt), 32'd15);
      en_forwarding = 1'b1;
      for (int i = 0; i < 20; i++) cycle("sat_fwd", 1'b0, 0, 0, 1'b0);
      chk("sat_s_fwd_cnt", 32'(s_fwd_cnt), 32'd15);
      freeze = 1'b1;
      clr_cnt = 1'b1;
      cycle("clr_frz", 1'b0, 0, 0, 1'b0);
      chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("clr_fwd_cnt", 32'(fwd_cnt), 32'd0);
      freeze = 1'b0;
      clr_cnt = 1'b0;
      for (int i = 0; i < 3; i++) cycle("post_clr", 1'b0, 0, 0, 1'b0);

      // Asynchronous reset in the middle of a cycle with a live forward.
      #3;
      chk("pre_rst_sel1", 32'(sel_src1), 32'd1);
      rst = 1'b0;
      #1;
      chk("async_rst_sel1", 32'(sel_src1), 32'd0);
      chk("async_rst_stall", 32'(stall), 32'd0);
      chk("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("async_rst_fwd_cnt", 32'(fwd_cnt), 32'd0);
      @(posedge clk);
      #1;
      do_reset();

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 7) != 0), REG_W'($urandom_range(0, 3)), 1'($urandom),
               REG_W'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               REG_W'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
         en_forwarding = ($urandom_range(0, 3) != 0);
         freeze = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 7) == 0);
         clr_cnt = ($urandom_range(0, 31) == 0);
         cycle("rand", 1'b0, 0, 0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
